// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle between the countdown timer and its neighbours
// (tick divider, button logic, display and LED/buzzer stages).
interface bcd_countdown_timer_if;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       stop;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       expired;
  logic       done;

  modport master (
    output tick, load, load_min, load_sec, start, stop,
    input  min_bcd, sec_bcd, running, expired, done
  );

  modport slave (
    input  tick, load, load_min, load_sec, start, stop,
    output min_bcd, sec_bcd, running, expired, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer advanced by a 1 Hz enable tick, with loadable
// preset, start/stop/pause and optional auto-reload on expiry.
module bcd_countdown_timer #(
  parameter bit AUTO_RELOAD  = 1'b0,
  parameter int MAX_MIN_TENS = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_countdown_timer_if.slave bus
);
  localparam logic [3:0] MT_LIM = MAX_MIN_TENS[3:0];

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] preset, preset_nx;
  logic        done_q, done_nx;
  logic [15:0] ld_val, cnt_dec;

  function automatic logic [3:0] clip(logic [3:0] v, logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // One-second BCD decrement; caller guarantees cnt != 00:00.
  function automatic logic [15:0] dec(logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) r[3:0] = c[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) r[7:4] = c[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (c[11:8] != 4'd0) r[11:8] = c[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = c[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign ld_val  = {clip(bus.load_min[7:4], MT_LIM), clip(bus.load_min[3:0], 4'd9),
                    clip(bus.load_sec[7:4], 4'd5),   clip(bus.load_sec[3:0], 4'd9)};
  assign cnt_dec = dec(cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 16'h0000;
      preset <= 16'h0000;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      preset <= preset_nx;
      done_q <= done_nx;
    end
  end

  // Priority load > stop > start > tick. A start in RUN has no effect,
  // so it does not mask a tick arriving in the same cycle.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    preset_nx = preset;
    done_nx   = 1'b0;
    if (bus.load) begin
      cnt_nx    = ld_val;
      preset_nx = ld_val;
      state_nx  = IDLE;
    end else if (bus.stop) begin
      if (state == RUN) state_nx = PAUSE;
    end else if (bus.start && state != RUN) begin
      case (state)
        IDLE, PAUSE: if (cnt != 16'h0000) state_nx = RUN;
        EXPIRED: if (preset != 16'h0000) begin
          cnt_nx   = preset;
          state_nx = RUN;
        end
        default: ;
      endcase
    end else if (bus.tick && state == RUN) begin
      if (cnt == 16'h0000) cnt_nx = preset;  // auto-reload after the 00:00 hold period
      else begin
        cnt_nx = cnt_dec;
        if (cnt_dec == 16'h0000) begin
          done_nx = 1'b1;
          if (!AUTO_RELOAD) state_nx = EXPIRED;
        end
      end
    end
  end

  assign bus.min_bcd = cnt[15:8];
  assign bus.sec_bcd = cnt[7:0];
  assign bus.running = (state == RUN);
  assign bus.expired = (state == EXPIRED);
  assign bus.done    = done_q;
endmodule
